// File: rtl/wb_arb_pkg.sv
// ============================================================================
// wb_arb_pkg : shared types and helpers for the two-master Wishbone arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package wb_arb_pkg;

    localparam int NB_MASTERS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // One-hot owner vector, bit n set while master n holds the slave.
    function automatic logic [NB_MASTERS-1:0] grant_vec(input arb_state_t s);
        return {(s == OWN1), (s == OWN0)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/wshb_if.sv
// ============================================================================
// wshb_if : classic Wishbone bus bundle with master and slave views
// Rev 1.0
// ============================================================================
`default_nettype none

interface wshb_if #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input logic clk,
    input logic rst
);

    logic            cyc;
    logic            stb;
    logic            we;
    logic [AW-1:0]   adr;
    logic [DW/8-1:0] sel;
    logic [DW-1:0]   dat_ms;
    logic [DW-1:0]   dat_sm;
    logic            ack;

    modport master (
        input  clk, rst,
        output cyc, stb, we, adr, sel, dat_ms,
        input  dat_sm, ack
    );

    modport slave (
        input  clk, rst,
        input  cyc, stb, we, adr, sel, dat_ms,
        output dat_sm, ack
    );

endinterface

`default_nettype wire

// File: rtl/wb_arb_mux.sv
// ============================================================================
// wb_arb_mux : steers the owning master onto the shared slave and routes ack
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_arb_mux
    import wb_arb_pkg::*;
(
    input  arb_state_t i_state,
    wshb_if.slave      wb_m0,
    wshb_if.slave      wb_m1,
    wshb_if.master     wb_s
);

    logic w_own0;
    logic w_own1;

    assign w_own0 = (i_state == OWN0);
    assign w_own1 = (i_state == OWN1);

    // Slave side depends only on state and master signals, never on ack.
    assign wb_s.cyc    = (w_own0 & wb_m0.cyc) | (w_own1 & wb_m1.cyc);
    assign wb_s.stb    = (w_own0 & wb_m0.stb) | (w_own1 & wb_m1.stb);
    assign wb_s.we     = (w_own0 & wb_m0.we)  | (w_own1 & wb_m1.we);
    assign wb_s.adr    = w_own1 ? wb_m1.adr    : (w_own0 ? wb_m0.adr    : '0);
    assign wb_s.sel    = w_own1 ? wb_m1.sel    : (w_own0 ? wb_m0.sel    : '0);
    assign wb_s.dat_ms = w_own1 ? wb_m1.dat_ms : (w_own0 ? wb_m0.dat_ms : '0);

    assign wb_m0.ack    = w_own0 & wb_s.ack;
    assign wb_m1.ack    = w_own1 & wb_s.ack;
    assign wb_m0.dat_sm = wb_s.dat_sm;
    assign wb_m1.dat_sm = wb_s.dat_sm;

endmodule

`default_nettype wire

// File: rtl/wb_arbiter_2m.sv
// ============================================================================
// wb_arbiter_2m : round-robin two-master Wishbone arbiter with burst limit
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_arbiter_2m
    import wb_arb_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    wshb_if.slave                 wb_m0,
    wshb_if.slave                 wb_m1,
    wshb_if.master                wb_s,
    output logic [NB_MASTERS-1:0] gnt
);

    localparam bit               c_PREEMPT_EN = (MAX_BURST > 0);
    localparam logic [CNT_W-1:0] c_BURST_LAST = c_PREEMPT_EN ? CNT_W'(MAX_BURST - 1) : '0;
    localparam logic [CNT_W-1:0] c_BURST_MAX  = CNT_W'(MAX_BURST);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_req0;
    logic             w_req1;
    logic             w_ack;
    logic             w_burst_done;

    assign w_req0 = wb_m0.cyc;
    assign w_req1 = wb_m1.cyc;
    assign w_ack  = wb_s.ack;

    // Preemption only fires on an ack cycle so a registered read ack can
    // never land on the next owner.
    assign w_burst_done = c_PREEMPT_EN && w_ack && (r_cnt == c_BURST_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (w_req0 && w_req1) begin
                    w_state_nxt = r_last ? OWN0 : OWN1;
                end else if (w_req0) begin
                    w_state_nxt = OWN0;
                end else if (w_req1) begin
                    w_state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (!w_req0) begin
                    w_state_nxt = w_req1 ? OWN1 : IDLE;
                    w_last_nxt  = 1'b0;
                end else if (w_req1 && w_burst_done) begin
                    w_state_nxt = OWN1;
                    w_last_nxt  = 1'b0;
                end
            end
            OWN1: begin
                if (!w_req1) begin
                    w_state_nxt = w_req0 ? OWN0 : IDLE;
                    w_last_nxt  = 1'b1;
                end else if (w_req0 && w_burst_done) begin
                    w_state_nxt = OWN0;
                    w_last_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Beat counter restarts on every ownership change and saturates.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end else if ((r_state != IDLE) && w_ack && (r_cnt != c_BURST_MAX)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    assign gnt = grant_vec(r_state);

    wb_arb_mux u_mux (
        .i_state (r_state),
        .wb_m0   (wb_m0),
        .wb_m1   (wb_m1),
        .wb_s    (wb_s)
    );

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter_2m.sv
// ============================================================================
// tb_wb_arbiter_2m : scoreboard bench, four arbiters with different bursts
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wb_arbiter_2m;

    localparam int c_NI = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        m_cyc [c_NI][2];
    logic        m_stb [c_NI][2];
    logic        m_we  [c_NI][2];
    logic [31:0] m_adr [c_NI][2];
    logic [31:0] m_dat [c_NI][2];
    logic [3:0]  m_sel [c_NI][2];
    wire         m_ack [c_NI][2];
    wire  [31:0] m_dsm [c_NI][2];
    wire  [1:0]  gnt_a [c_NI];
    wire         s_stb [c_NI];
    wire         s_cyc [c_NI];

    typedef struct {
        int          m;
        bit          rd;
        logic [31:0] dat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks;
    int   n_errors;
    int   sel;
    bit   mon_en;

    // Instance k: MAX_BURST = 16, 4, 2, 0 with a private BRAM model.
    for (genvar k = 0; k < c_NI; k++) begin : g_dut
        localparam int c_MB = (k == 0) ? 16 : (k == 1) ? 4 : (k == 2) ? 2 : 0;

        wshb_if u_m0 (.clk(clk), .rst(rst_n));
        wshb_if u_m1 (.clk(clk), .rst(rst_n));
        wshb_if u_s  (.clk(clk), .rst(rst_n));

        assign u_m0.cyc    = m_cyc[k][0];
        assign u_m0.stb    = m_stb[k][0];
        assign u_m0.we     = m_we[k][0];
        assign u_m0.adr    = m_adr[k][0];
        assign u_m0.sel    = m_sel[k][0];
        assign u_m0.dat_ms = m_dat[k][0];
        assign u_m1.cyc    = m_cyc[k][1];
        assign u_m1.stb    = m_stb[k][1];
        assign u_m1.we     = m_we[k][1];
        assign u_m1.adr    = m_adr[k][1];
        assign u_m1.sel    = m_sel[k][1];
        assign u_m1.dat_ms = m_dat[k][1];
        assign m_ack[k][0] = u_m0.ack;
        assign m_ack[k][1] = u_m1.ack;
        assign m_dsm[k][0] = u_m0.dat_sm;
        assign m_dsm[k][1] = u_m1.dat_sm;
        assign s_stb[k]    = u_s.stb;
        assign s_cyc[k]    = u_s.cyc;

        wb_arbiter_2m #(.MAX_BURST(c_MB), .CNT_W(5)) u_dut (
            .clk   (clk),
            .rst   (rst_n),
            .wb_m0 (u_m0.slave),
            .wb_m1 (u_m1.slave),
            .wb_s  (u_s.master),
            .gnt   (gnt_a[k])
        );

        logic [31:0] mem [64];
        logic        r_rack = 1'b0;
        logic [31:0] r_rdat;

        initial for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + 32'(i);

        always @(posedge u_s.clk) begin
            if (!u_s.rst) r_rack <= 1'b0;
            else          r_rack <= u_s.cyc && u_s.stb && !u_s.we && !r_rack;
            if (u_s.cyc && u_s.stb && u_s.we)
                for (int b = 0; b < 4; b++)
                    if (u_s.sel[b]) mem[u_s.adr[7:2]][8*b +: 8] <= u_s.dat_ms[8*b +: 8];
            r_rdat <= mem[u_s.adr[7:2]];
        end

        assign u_s.ack    = (u_s.cyc && u_s.stb && u_s.we) || r_rack;
        assign u_s.dat_sm = r_rdat;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_n(input int m, input int n, input bit rd, input logic [31:0] d0);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.m = m; e.rd = rd; e.dat = d0 + 32'(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic clear_all();
        for (int k = 0; k < c_NI; k++)
            for (int m = 0; m < 2; m++) begin
                m_cyc[k][m] = 1'b0; m_stb[k][m] = 1'b0; m_we[k][m] = 1'b0;
                m_adr[k][m] = '0;   m_dat[k][m] = '0;   m_sel[k][m] = 4'hF;
            end
    endtask

    task automatic drive(input int k, input int m, input bit we, input logic [31:0] a, input logic [31:0] d);
        m_cyc[k][m] = 1'b1; m_stb[k][m] = 1'b1; m_we[k][m] = we;
        m_adr[k][m] = a;    m_dat[k][m] = d;    m_sel[k][m] = 4'hF;
    endtask

    task automatic idle_m(input int k, input int m);
        m_cyc[k][m] = 1'b0; m_stb[k][m] = 1'b0; m_we[k][m] = 1'b0;
    endtask

    // Back-to-back transfers holding cyc; called just after a rising edge.
    task automatic xfer(input int k, input int m, input int n, input bit we,
                        input logic [31:0] a0, input logic [31:0] d0);
        int t;
        bit got;
        for (int i = 0; i < n; i++) begin
            drive(k, m, we, a0 + 32'(4 * i), d0 + 32'(i));
            t = 0; got = 1'b0;
            while (!got && t < 300) begin
                @(negedge clk);
                t++;
                got = m_ack[k][m];
            end
            if (!got) begin
                n_checks++; n_errors++;
                $display("FAIL xfer_timeout inst%0d m%0d beat %0d actual=no_ack expected=ack", k, m, i);
                break;
            end
            @(posedge clk); #1;
        end
        idle_m(k, m);
    endtask

    task automatic reset_dut();
        clear_all();
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_gnt", 32'(gnt_a[sel]), 32'h0);
        chk("rst_scyc", 32'(s_cyc[sel]), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic settle(input string name);
        repeat (4) @(posedge clk);
        #1;
        chk(name, 32'(exp_q.size()), 32'h0);
    endtask

    // Scoreboard monitor: every ack pops the next expected transfer.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int m = 0; m < 2; m++) begin
                if (m_ack[sel][m] === 1'b1) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL sb_unexpected_ack actual=m%0d gnt=%b expected=none", m, gnt_a[sel]);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.m != m || gnt_a[sel] != 2'(1 << m) ||
                            (mon_e.rd && m_dsm[sel][m] !== mon_e.dat)) begin
                            n_errors++;
                            $display("FAIL sb_ack inst%0d actual=m%0d gnt=%b dat=%h expected=m%0d gnt=%b dat=%h",
                                     sel, m, gnt_a[sel], m_dsm[sel][m], mon_e.m, 2'(1 << mon_e.m), mon_e.dat);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_errors = 0; mon_en = 1'b0; sel = 0;
        clear_all();
        rst_n = 1'b0;

        // Single write from m0
        sel = 0; reset_dut(); mon_en = 1'b1;
        push_n(0, 1, 1'b0, 32'h0);
        drive(0, 0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk); chk("t1_gnt_idle", 32'(gnt_a[0]), 32'h0);
        @(negedge clk); chk("t1_gnt_own0", 32'(gnt_a[0]), 32'h1);
        chk("t1_stb", 32'(s_stb[0]), 32'h1);
        chk("t1_ack", 32'(m_ack[0][0]), 32'h1);
        @(posedge clk); #1; idle_m(0, 0);
        @(negedge clk); chk("t1_gnt_hold", 32'(gnt_a[0]), 32'h1);
        @(negedge clk); chk("t1_gnt_rel", 32'(gnt_a[0]), 32'h0);
        chk("t1_bram_w4", g_dut[0].mem[4], 32'hDEAD_BEEF);
        settle("t1_drained");

        // Tie from reset, hand-over without idle, m1 registered read
        reset_dut();
        push_n(0, 1, 1'b0, 32'h0);
        push_n(1, 1, 1'b1, 32'hDEAD_BEEF);
        drive(0, 0, 1'b1, 32'h14, 32'h1111_1111);
        drive(0, 1, 1'b0, 32'h10, 32'h0);
        @(negedge clk); chk("t2_gnt_idle", 32'(gnt_a[0]), 32'h0);
        @(negedge clk); chk("t2_gnt_m0", 32'(gnt_a[0]), 32'h1);
        @(posedge clk); #1; idle_m(0, 0);
        @(negedge clk); chk("t2_gnt_hold", 32'(gnt_a[0]), 32'h1);
        @(negedge clk); chk("t2_gnt_m1", 32'(gnt_a[0]), 32'h2);
        chk("t2_rd_wait", 32'(m_ack[0][1]), 32'h0);
        @(negedge clk); chk("t2_rd_ack", 32'(m_ack[0][1]), 32'h1);
        @(posedge clk); #1; idle_m(0, 1);
        @(negedge clk); @(negedge clk); chk("t2_gnt_rel", 32'(gnt_a[0]), 32'h0);
        settle("t2_drained");

        // MAX_BURST=4: m0 preempted after 4 writes, resumes after m1
        sel = 1; reset_dut();
        push_n(0, 4, 1'b0, 32'h0);
        push_n(1, 1, 1'b0, 32'h0);
        push_n(0, 6, 1'b0, 32'h0);
        fork
            xfer(1, 0, 10, 1'b1, 32'h40, 32'hA000_0000);
            xfer(1, 1, 1, 1'b1, 32'h80, 32'hB000_0001);
        join
        settle("t3_drained");
        push_n(1, 1, 1'b1, 32'hA000_0009);
        xfer(1, 1, 1, 1'b0, 32'h64, 32'h0);
        push_n(0, 1, 1'b1, 32'hB000_0001);
        xfer(1, 0, 1, 1'b0, 32'h80, 32'h0);
        settle("t3_readback");

        // MAX_BURST=2 with registered reads on both sides
        sel = 2; reset_dut();
        push_n(0, 2, 1'b1, 32'hC0DE_0000);
        push_n(1, 2, 1'b1, 32'hC0DE_0008);
        push_n(0, 2, 1'b1, 32'hC0DE_0002);
        push_n(1, 1, 1'b1, 32'hC0DE_000A);
        push_n(0, 2, 1'b1, 32'hC0DE_0004);
        fork
            xfer(2, 0, 6, 1'b0, 32'h00, 32'h0);
            xfer(2, 1, 3, 1'b0, 32'h20, 32'h0);
        join
        settle("t4_drained");

        // Asynchronous reset while m1 owns the slave
        sel = 0; mon_en = 1'b0; reset_dut();
        drive(0, 1, 1'b1, 32'h30, 32'h5555_5555);
        @(negedge clk); @(negedge clk);
        chk("t5_gnt_m1", 32'(gnt_a[0]), 32'h2);
        rst_n = 1'b0; #1;
        chk("t5_rst_gnt", 32'(gnt_a[0]), 32'h0);
        chk("t5_rst_stb", 32'(s_stb[0]), 32'h0);
        chk("t5_rst_ack", 32'(m_ack[0][1]), 32'h0);
        drive(0, 0, 1'b1, 32'h34, 32'h6666_6666);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); chk("t5_gnt_m0", 32'(gnt_a[0]), 32'h1);
        @(posedge clk); #1; clear_all();

        // MAX_BURST=0: m1 keeps the slave for 50 beats
        sel = 3; reset_dut(); mon_en = 1'b1;
        push_n(1, 50, 1'b0, 32'h0);
        push_n(0, 1, 1'b0, 32'h0);
        fork
            xfer(3, 1, 50, 1'b1, 32'h00, 32'h6000_0000);
            begin
                repeat (3) @(posedge clk);
                #1;
                xfer(3, 0, 1, 1'b1, 32'hFC, 32'h7000_0000);
            end
        join
        settle("t6_drained");
        chk("t6_bram_m0", g_dut[3].mem[63], 32'h7000_0000);
        chk("t6_bram_m1", g_dut[3].mem[49], 32'h6000_0031);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
